// File: rtl/word_transmitter_pkg.sv
// Shared definitions for the serial word transmitter and its receiver-side tests.
// Holds the word size, the default address width and the transfer state encoding.
package word_transmitter_pkg;

  localparam int WORD_BITS      = 32;
  localparam int DEFAULT_ADDR_W = 12;
  localparam int BIT_CNT_W      = $clog2(WORD_BITS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic is_last_bit(input logic [BIT_CNT_W-1:0] cnt);
    return cnt == BIT_CNT_W'(WORD_BITS - 1);
  endfunction

endpackage

// File: rtl/word_transmitter_if.sv
// Host/memory/link signal bundle of the word transmitter.
// The master view belongs to the transmitter; the slave view is the host, RAM and link side.
interface word_transmitter_if #(
  parameter int ADDR_W = word_transmitter_pkg::DEFAULT_ADDR_W
);
  import word_transmitter_pkg::*;

  logic                 start;
  logic [ADDR_W-1:0]    num_words;
  logic [ADDR_W-1:0]    rd_addr;
  logic [WORD_BITS-1:0] rd_data;
  logic                 dataPin;
  logic                 dataOnPin;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, num_words, rd_data,
    output rd_addr, dataPin, dataOnPin, busy, done
  );

  modport slave (
    output start, num_words, rd_data,
    input  rd_addr, dataPin, dataOnPin, busy, done
  );

endinterface

// File: rtl/word_transmitter_bit_strobe_gen.sv
// Bit-period phase counter: strobe low for HALF_PERIOD cycles, then high for HALF_PERIOD.
// bit_end flags the last cycle of each period while run is held.
module word_transmitter_bit_strobe_gen #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic dataOnPin,
  output logic bit_end
);

  localparam int PERIOD = 2 * HALF_PERIOD;
  localparam int PH_W   = $clog2(PERIOD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(HALF_PERIOD);

  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_d;
  logic            strobe_q;
  logic            strobe_d;

  // The strobe is registered from the next phase so it never glitches on the pin.
  always_comb begin
    phase_d  = {PH_W{1'b0}};
    strobe_d = 1'b0;
    if (run) begin
      if (phase_q == PH_LAST) begin
        phase_d = {PH_W{1'b0}};
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
      strobe_d = (phase_d >= PH_HIGH);
    end else begin
      phase_d  = {PH_W{1'b0}};
      strobe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q  <= {PH_W{1'b0}};
      strobe_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      strobe_q <= strobe_d;
    end
  end

  assign dataOnPin = strobe_q;
  assign bit_end   = run && (phase_q == PH_LAST);

endmodule

// File: rtl/word_transmitter.sv
// Streams num_words 32-bit words from a synchronous-read RAM, starting at address 0,
// LSB first over a data line plus rising-edge sample strobe.
module word_transmitter
  import word_transmitter_pkg::*;
#(
  parameter int HALF_PERIOD = 2,
  parameter int ADDR_W      = DEFAULT_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  word_transmitter_if.master bus
);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    rem_q, rem_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 run_s;
  logic                 bit_end_s;
  logic                 strobe_s;

  assign run_s = (state_q == SHIFT);

  word_transmitter_bit_strobe_gen #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_bit_strobe_gen (
    .clk       (clk),
    .reset     (reset),
    .run       (run_s),
    .dataOnPin (strobe_s),
    .bit_end   (bit_end_s)
  );

  // Transfer sequencing: fetch, load, 32 bit periods per word, then next word or finish.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d    = {ADDR_W{1'b0}};
          rem_d     = bus.num_words;
          bit_cnt_d = {BIT_CNT_W{1'b0}};
          if (bus.num_words == {ADDR_W{1'b0}}) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d   = bus.rd_data;
        bit_cnt_d = {BIT_CNT_W{1'b0}};
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (bit_end_s) begin
          shift_d   = {1'b0, shift_q[WORD_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (is_last_bit(bit_cnt_q)) begin
            if (rem_q != ADDR_W'(1)) begin
              rem_d   = rem_q - ADDR_W'(1);
              addr_d  = addr_q + ADDR_W'(1);
              state_d = FETCH;
            end else begin
              state_d = DONE;
            end
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // done trails the DONE state by one cycle, the same cycle busy falls.
  assign busy_d = (state_d != IDLE);
  assign done_d = (state_q == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= {ADDR_W{1'b0}};
      rem_q     <= {ADDR_W{1'b0}};
      shift_q   <= {WORD_BITS{1'b0}};
      bit_cnt_q <= {BIT_CNT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.rd_addr   = addr_q;
  assign bus.dataPin   = shift_q[0];
  assign bus.dataOnPin = strobe_s;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_word_transmitter.sv
// Directed bench for word_transmitter: synchronous-read RAM model plus a serial
// receiver model that reassembles words on each strobe rising edge.
module tb_word_transmitter;

  logic clk;
  logic reset;

  word_transmitter_if #(.ADDR_W(12)) bus ();

  word_transmitter #(
    .HALF_PERIOD (2),
    .ADDR_W      (12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:15];
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr[3:0]];

  logic [31:0] rx_sr;
  logic [4:0]  rx_bits;
  int          rx_count = 0;
  logic [31:0] rx_words [0:15];

  always @(posedge bus.dataOnPin or negedge reset) begin
    if (!reset) begin
      rx_bits <= 5'd0;
      rx_sr   <= 32'd0;
    end else begin
      rx_sr   <= {bus.dataPin, rx_sr[31:1]};
      rx_bits <= rx_bits + 5'd1;
      if (rx_bits == 5'd31) begin
        rx_words[rx_count[3:0]] <= {bus.dataPin, rx_sr[31:1]};
        rx_count <= rx_count + 1;
      end
    end
  end

  int          tests = 0;
  int          fails = 0;
  int          n;
  int          nrise;
  int          rise_n [0:255];
  logic        prev_on;
  logic [11:0] addr_log [0:7];
  int          n_addr;
  logic [11:0] last_addr;
  int          at;
  int          rx_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    n++;
    if (bus.dataOnPin === 1'b1 && prev_on !== 1'b1) begin
      if (nrise < 256) rise_n[nrise] = n;
      nrise++;
    end
    prev_on = bus.dataOnPin;
    if (bus.busy === 1'b1 && bus.rd_addr !== last_addr && n_addr < 8) begin
      addr_log[n_addr] = bus.rd_addr;
      n_addr++;
      last_addr = bus.rd_addr;
    end
  endtask

  // Pulses start for one cycle; n=0 is the negedge right after the accepting edge.
  task automatic start_xfer(input logic [11:0] words);
    @(negedge clk);
    bus.num_words = words;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n         = 0;
    nrise     = 0;
    prev_on   = bus.dataOnPin;
    addr_log[0] = bus.rd_addr;
    n_addr    = 1;
    last_addr = bus.rd_addr;
  endtask

  task automatic wait_done(input int bound, output int done_at);
    done_at = -1;
    while (done_at < 0 && n < bound) begin
      step();
      if (bus.done === 1'b1) done_at = n;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    reset         = 1'b0;
    bus.start     = 1'b1;
    bus.num_words = 12'd5;
    n = 0; nrise = 0; prev_on = 1'b0; n_addr = 0; last_addr = 12'd0;

    // Reset held with start asserted
    repeat (5) @(negedge clk);
    check("rst_dataPin",   {31'd0, bus.dataPin},   32'd0);
    check("rst_dataOnPin", {31'd0, bus.dataOnPin}, 32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_done",      {31'd0, bus.done},      32'd0);
    check("rst_rd_addr",   {20'd0, bus.rd_addr},   32'd0);
    check("rst_no_strobe", rx_count,               32'd0);
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    // One word
    mem[0]  = 32'hA5A5_0001;
    rx_base = rx_count;
    start_xfer(12'd1);
    check("one_busy_k",  {31'd0, bus.busy},    32'd1);
    check("one_addr_k",  {20'd0, bus.rd_addr}, 32'd0);
    wait_done(400, at);
    check("one_done_at", at, 32'd131);
    check("one_busy_at_done", {31'd0, bus.busy}, 32'd0);
    check("one_first_rise", rise_n[0], 32'd4);
    step();
    check("one_done_pulse", {31'd0, bus.done}, 32'd0);
    check("one_strobes", nrise, 32'd32);
    check("one_rx_count", rx_count - rx_base, 32'd1);
    check("one_rx_word", rx_words[rx_base[3:0]], 32'hA5A5_0001);

    // Three words through the receiver model
    mem[0]  = 32'h0000_0001;
    mem[1]  = 32'h8000_0000;
    mem[2]  = 32'hFFFF_FFFF;
    rx_base = rx_count;
    start_xfer(12'd3);
    wait_done(1000, at);
    check("multi_done_at", at, 32'd391);
    check("multi_strobes", nrise, 32'd96);
    check("multi_gap", rise_n[32] - rise_n[31], 32'd6);
    check("multi_addr_cnt", n_addr, 32'd3);
    check("multi_addr0", {20'd0, addr_log[0]}, 32'd0);
    check("multi_addr1", {20'd0, addr_log[1]}, 32'd1);
    check("multi_addr2", {20'd0, addr_log[2]}, 32'd2);
    check("multi_rx_count", rx_count - rx_base, 32'd3);
    check("multi_rx_w0", rx_words[rx_base[3:0]],             32'h0000_0001);
    check("multi_rx_w1", rx_words[4'(rx_base + 1)],          32'h8000_0000);
    check("multi_rx_w2", rx_words[4'(rx_base + 2)],          32'hFFFF_FFFF);

    // Zero-length request
    start_xfer(12'd0);
    check("zero_busy_k", {31'd0, bus.busy},    32'd1);
    check("zero_addr_k", {20'd0, bus.rd_addr}, 32'd0);
    step();
    check("zero_done",   {31'd0, bus.done},    32'd1);
    check("zero_busy_done", {31'd0, bus.busy}, 32'd0);
    check("zero_addr_done", {20'd0, bus.rd_addr}, 32'd0);
    step();
    check("zero_done_pulse", {31'd0, bus.done}, 32'd0);
    check("zero_strobes", nrise, 32'd0);

    // Extra start while busy, then reset in the middle of bit 17
    mem[0]  = 32'h1234_5678;
    mem[1]  = 32'h9ABC_DEF0;
    rx_base = rx_count;
    start_xfer(12'd2);
    while (n < 73) begin
      step();
      if (n == 20) begin
        bus.num_words = 12'd7;
        bus.start     = 1'b1;
      end else if (n == 21) begin
        bus.start = 1'b0;
      end
    end
    check("guard_rises", nrise, 32'd18);
    check("guard_strobe_hi", {31'd0, bus.dataOnPin}, 32'd1);
    check("guard_addr", {20'd0, bus.rd_addr}, 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_strobe", {31'd0, bus.dataOnPin}, 32'd0);
    check("mid_rst_busy",   {31'd0, bus.busy},      32'd0);
    repeat (3) step();
    check("mid_rst_no_edges", nrise, 32'd18);
    check("mid_rst_no_word", rx_count - rx_base, 32'd0);
    reset = 1'b1;
    step();
    start_xfer(12'd1);
    check("restart_addr", {20'd0, bus.rd_addr}, 32'd0);
    wait_done(400, at);
    check("restart_done_at", at, 32'd131);
    check("restart_rx_count", rx_count - rx_base, 32'd1);
    check("restart_rx_word", rx_words[rx_base[3:0]], 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/word_transmitter.md
# word_transmitter

- Sends a block of 32-bit words from a word-addressed memory over the two-wire serial link: one data line plus one rising-edge sample strobe.
- Words go LSB-first, 32 strobes per word, at addresses 0, 1, 2, … in order. This matches the existing serial word receiver, so words land at the same addresses on the far end.
- Sits between the local data RAM (1-cycle synchronous read port) and the off-chip link pins.

## Interface

Parameters:
- HALF_PERIOD, 2: clk cycles the strobe spends low, and then high, per bit (≥1).
- ADDR_W, 12: memory address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to send num_words words; sampled only in IDLE.
- num_words  in  ADDR_W  word count, latched when start is accepted.
- rd_addr  out  ADDR_W  memory read address.
- rd_data  in  32  memory read data; valid one clk after rd_addr.
- dataPin  out  1  serial data line, LSB first.
- dataOnPin  out  1  sample strobe; the receiver samples dataPin on its rising edge.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the transfer completes.

## Operation

- States:
  - IDLE: busy=0. On start=1 → FETCH with addr=0, remaining=num_words. If num_words==0 → DONE directly.
  - FETCH: 1 cycle; rd_addr=addr.
  - LOAD: 1 cycle; shift_reg←rd_data.
  - SHIFT: 32 bit periods.
  - DONE: 1 cycle, done=1; then → IDLE.
- SHIFT bit period:
  - Phase counter runs 0..2·HALF_PERIOD−1.
  - Phases 0..HALF_PERIOD−1: dataOnPin=0. Phases HALF_PERIOD..end: dataOnPin=1.
  - dataPin = shift_reg[0]. It changes only on the edge that starts phase 0, so it is stable for HALF_PERIOD cycles before the strobe rises.
  - At end of period: shift_reg ← shift_reg>>1; bit count +1.
- After bit 31:
  - remaining−1 > 0 → addr+1, FETCH.
  - Otherwise → DONE.
- addr is ADDR_W bits and wraps modulo 2^ADDR_W. num_words = 2^ADDR_W−1 is legal (max count).
- start while busy: ignored, no effect.
- dataOnPin=0 in IDLE, FETCH, LOAD and DONE. The strobe never rises outside SHIFT phase HALF_PERIOD.
- Reset (async, any state):
  - State → IDLE.
  - Outputs: dataPin=0, dataOnPin=0, busy=0, done=0, rd_addr=0.
  - Counters cleared.
  - A word cut off mid-way is not resumed. The receiver is reset alongside it by system reset.

## Timing

- start accepted at edge k: busy=1 and rd_addr=0 from k.
- LOAD captures rd_data at edge k+2. The first bit period begins at k+2.
- First strobe rising edge at k+2+HALF_PERIOD.
- Per word: 2 + 64·HALF_PERIOD cycles (130 at default).
- Gap between the last strobe of word n and the first strobe of word n+1: HALF_PERIOD + 2 + HALF_PERIOD cycles.
- done asserts for one cycle starting at k + 1 + N·(2+64·HALF_PERIOD); busy falls in that same cycle.
- Minimum start-to-start spacing: transfer length + 1 cycle (through IDLE).

## Structure

- Shared package holds:
  - WORD_BITS=32
  - default ADDR_W=12
  - state enum {IDLE, FETCH, LOAD, SHIFT, DONE}, also used by the receiver-side tests
- One sub-module, bit_strobe_gen: the phase counter.
  - Inputs: clk, reset, run.
  - Outputs: dataOnPin, bit_end.
- Top level holds the FSM, the address/remaining counters and the 32-bit shift register.

## Test plan

- Reset: hold reset=0 with start=1 → all outputs 0, no strobes. Release → IDLE, busy=0.
- One word:
  - Stimulus: mem[0]=0xA5A5_0001, num_words=1, HALF_PERIOD=2.
  - Response: exactly 32 dataOnPin rising edges. Bits sampled at those edges, LSB first, reassemble 0xA5A5_0001. done pulses once, 131 cycles after start.
- Multi-word loopback:
  - Stimulus: num_words=3, mem[0..2]=0x1, 0x8000_0000, 0xFFFF_FFFF. Link drives the existing receiver.
  - Response: rd_addr sequence 0, 1, 2. Receiver's ready asserts 3 times, with its addr advancing 0→3 and its out matching each word.
- Zero length: start with num_words=0 → done 1 cycle later, no strobes, rd_addr stays 0.
- Busy guard and mid-transfer reset:
  - Stimulus: start pulse during word 0; later, reset=0 in the middle of bit 17.
  - Response: the extra start has no effect. On reset, dataOnPin drops immediately with no further edges, and a following start restarts at addr 0.
